// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared FSM states and SPI core register map for the burst sequencer
package spi_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_SS, S_SSO_ON, S_WAIT_TX, S_WR_TX,
    S_WAIT_RX, S_RD_RX, S_PUSH, S_SSO_OFF, S_DONE
  } state_t;
  localparam logic [2:0] RXDATA   = 3'd0;
  localparam logic [2:0] TXDATA   = 3'd1;
  localparam logic [2:0] STATUS   = 3'd2;
  localparam logic [2:0] CONTROL  = 3'd3;
  localparam logic [2:0] SLAVESEL = 3'd5;
  localparam logic [2:0] EOPVAL   = 3'd6;
  localparam int CTRL_SSO_BIT = 10;
endpackage

// File: rtl/spi_reg_access.sv
// spi_reg_access: one core register access, 2 cycles selected plus 1 idle cycle, then ack
module spi_reg_access #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_addr,
  input  logic [15:0]       i_wdata,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_select,
  output logic              o_read_n,
  output logic              o_write_n,
  output logic [2:0]        o_mem_addr,
  output logic [15:0]       o_wdata,
  input  logic [15:0]       i_rdata
);
  logic [1:0]        r_ph;
  logic              r_we;
  logic [2:0]        r_addr;
  logic [15:0]       r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_unused_rdata;

  assign w_unused_rdata = ^i_rdata;
  assign o_select   = r_ph[0] ^ r_ph[1];
  assign o_write_n  = !(o_select && r_we);
  assign o_read_n   = !(o_select && !r_we);
  assign o_mem_addr = r_addr;
  assign o_wdata    = r_wdata;
  assign o_ack      = r_ph == 2'd3;
  assign o_rdata    = r_rdata;

  // phase 0 idle, 1-2 selected, 3 idle gap with ack; latch request on accept, read data on last select cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_ph    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_ph <= (r_ph == 2'd0) ? {1'b0, i_req} : r_ph + 2'd1;
      if (r_ph == 2'd0 && i_req) begin
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (r_ph == 2'd2 && !r_we) r_rdata <= i_rdata[DATA_W-1:0];
    end
endmodule

// File: rtl/spi_burst_sequencer.sv
// spi_burst_sequencer: streams an N-byte full-duplex SPI burst through the core's register port
module spi_burst_sequencer
  import spi_seq_pkg::*;
#(
  parameter int          DATA_W  = 8,
  parameter int          LEN_W   = 8,
  parameter logic [15:0] SS_MASK = 16'h0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              done,
  output logic              spi_select,
  output logic              spi_read_n,
  output logic              spi_write_n,
  output logic [2:0]        spi_mem_addr,
  output logic [15:0]       spi_wdata,
  input  logic [15:0]       spi_rdata,
  input  logic              spi_readyfordata,
  input  logic              spi_dataavailable
);
  state_t            r_state, w_next;
  logic              w_req, w_we, w_ack, w_rx_hs, w_start;
  logic [2:0]        w_addr;
  logic [15:0]       w_wdata;
  logic [DATA_W-1:0] w_rdata, r_tx, r_rx_data;
  logic              r_rx_valid, r_busy, r_done;
  logic [LEN_W:0]    r_rem;

  assign cmd_ready = r_state == S_IDLE;
  assign w_start   = cmd_ready && cmd_valid;
  assign tx_ready  = r_state == S_WAIT_TX && tx_valid && spi_readyfordata;
  assign w_rx_hs   = r_rx_valid && rx_ready;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign busy      = r_busy;
  assign done      = r_done;

  spi_reg_access #(.DATA_W(DATA_W)) u_acc (
    .clk(clk), .reset_n(reset_n),
    .i_req(w_req), .i_we(w_we), .i_addr(w_addr), .i_wdata(w_wdata),
    .o_ack(w_ack), .o_rdata(w_rdata),
    .o_select(spi_select), .o_read_n(spi_read_n), .o_write_n(spi_write_n),
    .o_mem_addr(spi_mem_addr), .o_wdata(spi_wdata), .i_rdata(spi_rdata)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;

  // next state and register-access request; each access state holds req until ack
  always_comb begin
    w_next  = r_state;
    w_req   = 1'b0;
    w_we    = 1'b1;
    w_addr  = SLAVESEL;
    w_wdata = SS_MASK;
    case (r_state)
      S_IDLE:    w_next = cmd_valid ? S_WR_SS : S_IDLE;
      S_WR_SS: begin
        w_req  = 1'b1;
        w_next = w_ack ? S_SSO_ON : r_state;
      end
      S_SSO_ON: begin
        w_req   = 1'b1;
        w_addr  = CONTROL;
        w_wdata = 16'd1 << CTRL_SSO_BIT;
        w_next  = w_ack ? S_WAIT_TX : r_state;
      end
      S_WAIT_TX: w_next = tx_ready ? S_WR_TX : r_state;
      S_WR_TX: begin
        w_req   = 1'b1;
        w_addr  = TXDATA;
        w_wdata = 16'(r_tx);
        w_next  = w_ack ? S_WAIT_RX : r_state;
      end
      S_WAIT_RX: w_next = spi_dataavailable ? S_RD_RX : r_state;
      S_RD_RX: begin
        w_req   = 1'b1;
        w_we    = 1'b0;
        w_addr  = RXDATA;
        w_wdata = '0;
        w_next  = w_ack ? S_PUSH : r_state;
      end
      S_PUSH:    w_next = !w_rx_hs ? r_state : (r_rem == (LEN_W+1)'(1)) ? S_SSO_OFF : S_WAIT_TX;
      S_SSO_OFF: begin
        w_req   = 1'b1;
        w_addr  = CONTROL;
        w_wdata = '0;
        w_next  = w_ack ? S_DONE : r_state;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // byte counter, tx/rx holding registers, busy and done flags
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_rem      <= '0;
      r_tx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_start) r_rem <= (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len};
      else if (r_state == S_PUSH && w_rx_hs) r_rem <= r_rem - (LEN_W+1)'(1);
      if (tx_ready) r_tx <= tx_data;
      if (r_state == S_RD_RX && w_ack) r_rx_data <= w_rdata;
      r_rx_valid <= (r_state == S_RD_RX && w_ack) || (r_rx_valid && !rx_ready);
      r_busy     <= w_start || (r_busy && r_state != S_DONE);
      r_done     <= r_state == S_DONE;
    end
endmodule
